// File: rtl/window_generator_pkg.sv
// Shared filter constants: pixel/window widths and window FSM states.
// Imported by the window generator, its line buffers and the median filter.
package window_generator_pkg;

  localparam int PIXEL_W    = 8;
  localparam int WIN_PIXELS = 9;
  localparam int WIN_W      = PIXEL_W * WIN_PIXELS;

  typedef enum logic {
    S_FILL   = 1'b0,
    S_ACTIVE = 1'b1
  } wg_state_e;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixels: write and combinational read at a shared column.
// Ports: i_clk, i_we, i_col, i_wdata -> o_rdata (old value at i_col).
module line_buffer
  import window_generator_pkg::*;
#(
  parameter int DEPTH = 512,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_col,
  input  logic [PIXEL_W-1:0] i_wdata,
  output logic [PIXEL_W-1:0] o_rdata
);

  logic [PIXEL_W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_col] <= i_wdata;
  end

  // Read returns the pixel stored one line ago before this write lands.
  assign o_rdata = mem_q[i_col];

endmodule

// File: rtl/window_generator.sv
// Raster pixel stream to registered 3x3 windows for the median filter.
// Ports: i_clk, i_rst, i_pixel/i_pixel_valid -> o_pixel_data(_valid), o_frame_done.
module window_generator
  import window_generator_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIXEL_W-1:0] i_pixel,
  input  logic               i_pixel_valid,
  output logic [WIN_W-1:0]   o_pixel_data,
  output logic               o_pixel_data_valid,
  output logic               o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  wg_state_e          state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [WIN_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [PIXEL_W-1:0] lb1_rd, lb2_rd;
  logic               last_col, last_row;

  // lb1 holds row-1; lb2 holds row-2 and is fed from lb1's old value.
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .i_clk   (i_clk),
    .i_we    (i_pixel_valid),
    .i_col   (col_q),
    .i_wdata (i_pixel),
    .o_rdata (lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
    .i_clk   (i_clk),
    .i_we    (i_pixel_valid),
    .i_col   (col_q),
    .i_wdata (lb1_rd),
    .o_rdata (lb2_rd)
  );

  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    win_d   = win_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (i_pixel_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[(r*3)*PIXEL_W +: PIXEL_W]   = win_q[(r*3+1)*PIXEL_W +: PIXEL_W];
        win_d[(r*3+1)*PIXEL_W +: PIXEL_W] = win_q[(r*3+2)*PIXEL_W +: PIXEL_W];
      end
      win_d[2*PIXEL_W +: PIXEL_W] = lb2_rd;
      win_d[5*PIXEL_W +: PIXEL_W] = lb1_rd;
      win_d[8*PIXEL_W +: PIXEL_W] = i_pixel;

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      done_d = last_col && last_row;

      unique case (state_q)
        S_FILL: begin
          if (last_col && row_q == ROW_ONE) state_d = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (col_q >= CW'(2)) begin
            valid_d = 1'b1;
            data_d  = win_d;
          end
          if (last_col && last_row) state_d = S_FILL;
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= S_FILL;
      win_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      win_q   <= win_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign o_pixel_data       = data_q;
  assign o_pixel_data_valid = valid_q;
  assign o_frame_done       = done_q;

endmodule

// File: tb/tb_window_generator.sv
// Directed bench for window_generator with a 4x4 image.
// Expected windows are hand-computed for a 0..15 ramp frame.
module tb_window_generator;

  localparam int W = 4;
  localparam int H = 4;
  localparam logic [71:0] FRAME_OFS = 72'h101010101010101010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix = '0;
  logic        pv  = 1'b0;
  logic [71:0] pd;
  logic        pdv;
  logic        fd;

  always #5 clk = ~clk;

  window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pixel            (pix),
    .i_pixel_valid      (pv),
    .o_pixel_data       (pd),
    .o_pixel_data_valid (pdv),
    .o_frame_done       (fd)
  );

  typedef struct {
    logic [71:0] d;
    logic        done;
  } win_t;

  win_t wq[$];
  win_t exp_tbl[4];
  int   done_cnt = 0;
  int   checks   = 0;
  int   failures = 0;

  always begin
    @(posedge clk);
    #2;
    if (pdv) wq.push_back('{d: pd, done: fd});
    if (fd) done_cnt++;
  end

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pv  = 1'b0;
      pix = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send(input logic [7:0] p, input int max_gap);
    idle($urandom_range(0, max_gap));
    @(negedge clk);
    pix = p;
    pv  = 1'b1;
  endtask

  task automatic ramp(input logic [7:0] base, input int from, input int to,
                      input int max_gap);
    for (int i = from; i <= to; i++) send(base + 8'(i), max_gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pv  = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    wq.delete();
    done_cnt = 0;
  endtask

  task automatic cmp_frames(input string tag, input int nfr);
    chk({tag, "_count"}, 72'(wq.size()), 72'(4 * nfr));
    chk({tag, "_done_cnt"}, 72'(done_cnt), 72'(nfr));
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = f * 4 + i;
        if (k < wq.size()) begin
          chk($sformatf("%s_win%0d", tag, k), wq[k].d,
              exp_tbl[i].d + FRAME_OFS * 72'(f));
          chk($sformatf("%s_done%0d", tag, k), 72'(wq[k].done),
              72'(exp_tbl[i].done));
        end else begin
          checks++;
          failures++;
          $display("FAIL %s_win%0d actual=missing required=present", tag, k);
        end
      end
    end
  endtask

  initial begin
    exp_tbl[0] = '{d: 72'h0A0908060504020100, done: 1'b0};
    exp_tbl[1] = '{d: 72'h0B0A09070605030201, done: 1'b0};
    exp_tbl[2] = '{d: 72'h0E0D0C0A0908060504, done: 1'b0};
    exp_tbl[3] = '{d: 72'h0F0E0D0B0A09070605, done: 1'b1};

    idle(2);
    chk("rst_valid", 72'(pdv), 72'(0));
    chk("rst_done", 72'(fd), 72'(0));
    chk("rst_data", pd, 72'h0);
    rst = 1'b0;
    idle(1);
    wq.delete();
    done_cnt = 0;

    // Back-to-back ramp; first window one cycle after pixel 10.
    ramp(8'h00, 0, 10, 0);
    idle(1);
    chk("first_valid", 72'(pdv), 72'(1));
    chk("first_data", pd, 72'h0A0908060504020100);
    chk("first_count", 72'(wq.size()), 72'(1));
    ramp(8'h00, 11, 15, 0);
    idle(4);
    chk("hold_valid", 72'(pdv), 72'(0));
    chk("hold_data", pd, 72'h0F0E0D0B0A09070605);
    cmp_frames("b2b", 1);

    // Same ramp with random idle gaps.
    do_reset();
    ramp(8'h00, 0, 15, 3);
    idle(4);
    cmp_frames("gaps", 1);

    // Two frames with no dead cycle between them.
    do_reset();
    ramp(8'h00, 0, 15, 0);
    ramp(8'h10, 0, 15, 0);
    idle(4);
    cmp_frames("two", 2);
    if (wq.size() > 4) chk("two_fifth", wq[4].d, 72'h1A1918161514121110);
    else chk("two_fifth_present", 72'(wq.size()), 72'(5));

    // Reset after pixel 9, then a fresh ramp.
    do_reset();
    ramp(8'h00, 0, 9, 0);
    @(negedge clk);
    pv  = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("mid_rst_no_valid", 72'(wq.size()), 72'(0));
    chk("mid_rst_data", pd, 72'h0);
    chk("mid_rst_no_done", 72'(done_cnt), 72'(0));
    ramp(8'h00, 0, 15, 0);
    idle(4);
    cmp_frames("after_rst", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 512, pixels per line (minimum 3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 512, lines per frame (minimum 3).
REQ-003 SHALL have port i_clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_pixel, input, 8, raster-order pixel, sampled when i_pixel_valid=1.
REQ-006 SHALL have port i_pixel_valid, input, 1, pixel accept strobe; no backpressure, so every valid cycle is one pixel.
REQ-007 SHALL have port o_pixel_data, output, 72, 3x3 window; byte k=[k*8+:8], k=row*3+col, row 0 = oldest line, col 0 = leftmost pixel.
REQ-008 SHALL have port o_pixel_data_valid, output, 1, window strobe; matches the median filter's 72-bit data/valid input.
REQ-009 SHALL have port o_frame_done, output, 1, one-cycle pulse after the last pixel of a frame.

Function
REQ-010 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), advanced only on accepted pixels.
REQ-011 SHALL wrap col to 0 and increment row on accepting col=IMG_WIDTH-1; on accepting (IMG_HEIGHT-1, IMG_WIDTH-1), SHALL wrap both counters to 0.
REQ-012 SHALL store the two previous lines in two line buffers, each IMG_WIDTH x 8; at each accept, the line buffers SHALL supply the pixels at the same col from rows row-1 and row-2.
REQ-013 SHALL shift a 3-column window register on each accept: rows (row-2, row-1, row) at col enter as column 2; older columns shift left.
REQ-014 SHALL use FSM states S_FILL (row<2) and S_ACTIVE (row>=2); S_FILL->S_ACTIVE on accepting the last pixel of row 1; S_ACTIVE->S_FILL on accepting the last pixel of the frame.
REQ-015 SHALL, in S_ACTIVE, assert o_pixel_data_valid for exactly one cycle, one cycle after accepting a pixel with col>=2.
REQ-016 SHALL otherwise hold o_pixel_data_valid at 0 (no border padding); each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
REQ-017 SHALL present o_pixel_data with rows row-2..row and cols col-2..col of the triggering pixel; it SHALL hold its value when o_pixel_data_valid=0.
REQ-018 SHALL assert o_frame_done one cycle after the last pixel of the frame is accepted, in the same cycle as the final window valid.
REQ-019 SHALL produce identical window content regardless of idle gaps (i_pixel_valid=0) between pixels.
REQ-020 SHALL accept the first pixel of the next frame in the cycle after the last pixel of the current frame, with no dead cycle.

Reset
REQ-021 SHALL, on i_rst=1 at any time including mid-frame, clear col, row, state=S_FILL, o_pixel_data=0, o_pixel_data_valid=0, o_frame_done=0.
REQ-022 SHALL NOT require clearing line-buffer contents on reset; stale data SHALL be overwritten before any window is emitted.
REQ-023 SHALL treat the first accepted pixel after reset deassertion as pixel (0,0) of a new frame.

Structure
REQ-024 SHALL take PIXEL_W=8, WIN_PIXELS=9, WIN_W=72 and FSM state encodings from the shared filter constants package used by the median filter.
REQ-025 SHALL instantiate the two line buffers as one sub-module, line_buffer (parameter DEPTH, 8-bit write/read at a shared column index, write enable).
REQ-026 SHALL make o_pixel_data and o_pixel_data_valid registers, so they can connect directly to the median filter.

Verification
REQ-027 With W=4, H=4, ramp pixels 0..15 back-to-back: first valid follows pixel 10; o_pixel_data=0x0A0908060504020100; 4 windows total; o_frame_done coincides with the 4th window.
REQ-028 Same ramp with 0-3 random idle cycles between pixels: the same 4 windows in the same order; valid never exceeds 1 cycle per window.
REQ-029 Two back-to-back frames (ramp, then ramp+16): 8 windows; the 5th window equals 0x1A1918161514121110; no window mixes frames.
REQ-030 Assert i_rst after pixel 9 of a frame, then restart the ramp: no valid during or immediately after reset; the next windows match REQ-027.
REQ-031 Default parameters chained to the median filter, constant frame of 0x07: 510*510 median outputs all 0x07; exactly one o_frame_done.
